// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray-code synchronizer/decoder path.
package gray_pkg;

    localparam int unsigned DEFAULT_SIZE        = 4;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned MAX_W               = 32;
    localparam int unsigned POP_W               = $clog2(MAX_W + 1);

    // Words narrower than MAX_W are zero-extended; leading zeros decode to zeros.
    function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_W; i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_binary.sv
// Combinational Gray-to-binary decoder, inverse of the upstream binary-to-Gray encoder.
module gray_binary
    import gray_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin_c
);

    assign bin_c = SIZE'(gray_to_bin(MAX_W'(gray)));

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronizes a Gray count from a foreign clock domain, decodes it to binary and
// classifies each observed change as a single up/down step or a multi-bit corruption.
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int unsigned SIZE        = DEFAULT_SIZE,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] gray_in,
    input  logic            err_clr,
    output logic [SIZE-1:0] bin_out,
    output logic            valid,
    output logic            step,
    output logic            dir,
    output logic            err,
    output logic            err_sticky
);

    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    (* ASYNC_REG = "TRUE" *) logic [SIZE-1:0] sync_q [SYNC_STAGES];

    logic [SIZE-1:0]   gray_s;
    logic [SIZE-1:0]   gray_q;
    logic [SIZE-1:0]   bin_s_c;
    logic [FILL_W-1:0] fill_q;
    logic [POP_W-1:0]  diff_c;
    logic              one_step_c;
    logic              multi_c;
    logic              up_c;

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gray_s = sync_q[SYNC_STAGES-1];

    gray_binary #(.SIZE(SIZE)) u_gray_binary (
        .gray  (gray_s),
        .bin_c (bin_s_c)
    );

    // Change classification against the previously accepted sample.
    always_comb begin
        diff_c     = '0;
        one_step_c = 1'b0;
        multi_c    = 1'b0;
        up_c       = 1'b0;
        diff_c     = popcount(MAX_W'(gray_s ^ gray_q));
        one_step_c = valid && (diff_c == POP_W'(1));
        multi_c    = valid && (diff_c > POP_W'(1));
        up_c       = (bin_s_c == (bin_out + SIZE'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q     <= '0;
            gray_q     <= '0;
            bin_out    <= '0;
            valid      <= 1'b0;
            step       <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            step <= one_step_c;
            err  <= multi_c;
            if (one_step_c) begin
                dir <= up_c;
            end
            // Fill waits until the chain holds a real sample before accepting it.
            if (!valid) begin
                if (fill_q != FILL_W'(SYNC_STAGES)) begin
                    fill_q <= fill_q + FILL_W'(1);
                end else begin
                    gray_q  <= gray_s;
                    bin_out <= bin_s_c;
                    valid   <= 1'b1;
                end
            end else begin
                gray_q  <= gray_s;
                bin_out <= bin_s_c;
            end
            if (multi_c) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
